// File: rtl/core_mem_ctrl_pkg.sv
// core_pkg: shared status/state encodings, word width and counter helper for core_mem_ctrl.
package core_pkg;

    localparam int WORD_W = 16;
    localparam int CNT_W  = 16;

    localparam logic [1:0] STATUS_IDLE    = 2'd0;
    localparam logic [1:0] STATUS_RUN     = 2'd1;
    localparam logic [1:0] STATUS_DONE    = 2'd2;
    localparam logic [1:0] STATUS_TIMEOUT = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = STATUS_IDLE,
        ST_RUN     = STATUS_RUN,
        ST_DONE    = STATUS_DONE,
        ST_TIMEOUT = STATUS_TIMEOUT
    } state_t;

    // Saturating increment: the RUN-cycle counter must never wrap back to 0.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/sp_ram16.sv
// sp_ram16: 2^AW x 16-bit RAM, one write port and one registered read port (read-before-write).
module sp_ram16
    import core_pkg::*;
#(
    parameter int AW = 8
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [WORD_W-1:0] i_wdata,
    input  logic [AW-1:0]     i_raddr,
    output logic [WORD_W-1:0] o_rdata
);

    logic [WORD_W-1:0] r_mem [0:(1<<AW)-1];
    logic [WORD_W-1:0] r_rdata;

    // NOTE: the array has no reset branch so it maps onto RAM macros and keeps its contents across reset.
    always_ff @(posedge clock) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // NOTE: non-blocking update of r_mem means a same-address read in this cycle sees the old word.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/core_mem_ctrl.sv
// core_mem_ctrl: run-control FSM with watchdog plus host/processor access to instruction and data RAMs.
// Optional macro CORE_MEM_CTRL_CYCLE_COUNT_EN adds the cycle_count output port.
module core_mem_ctrl
    import core_pkg::*;
#(
    parameter int IM_AW      = 8,
    parameter int DM_AW      = 8,
    parameter int MAX_CYCLES = 4096
) (
    input  logic        clock,
    input  logic        rst_n,
    input  logic        host_we,
    input  logic        host_sel,
    input  logic [15:0] host_addr,
    input  logic [15:0] host_wdata,
    output logic [15:0] host_rdata,
    input  logic        start,
    output logic [1:0]  status,
    input  logic [15:0] pc_out,
    output logic [15:0] im_out,
    input  logic [15:0] ar_out,
    input  logic        dm_en,
    input  logic [15:0] r2_out,
    output logic [15:0] dm_out,
    input  logic        end_process,
    output logic        busy
`ifdef CORE_MEM_CTRL_CYCLE_COUNT_EN
    ,
    output logic [15:0] cycle_count
`endif
);

    localparam logic [CNT_W-1:0] WD_LAST = 16'(MAX_CYCLES - 1);

    state_t             r_state;
    logic               r_busy;
    logic [CNT_W-1:0]   r_cycles;
    logic               r_host_rd_en;
    logic               r_host_sel;

    logic               w_run;
    logic               w_im_we;
    logic [IM_AW-1:0]   w_im_raddr;
    logic [WORD_W-1:0]  w_im_rdata;
    logic               w_dm_we;
    logic [DM_AW-1:0]   w_dm_waddr;
    logic [WORD_W-1:0]  w_dm_wdata;
    logic [DM_AW-1:0]   w_dm_raddr;
    logic [WORD_W-1:0]  w_dm_rdata;
    logic               w_unused_bits;

    assign w_run = (r_state == ST_RUN);

    // Outside RUN the host owns the write ports and the read port of the memory it selects;
    // writes are gated by rst_n so a reset edge never commits a write.
    assign w_im_we    = rst_n && !w_run && host_we && !host_sel;
    assign w_im_raddr = (!w_run && !host_sel) ? host_addr[IM_AW-1:0] : pc_out[IM_AW-1:0];

    assign w_dm_we    = rst_n && (w_run ? dm_en : (host_we && host_sel));
    assign w_dm_waddr = w_run ? ar_out[DM_AW-1:0] : host_addr[DM_AW-1:0];
    assign w_dm_wdata = w_run ? r2_out : host_wdata;
    assign w_dm_raddr = (!w_run && host_sel) ? host_addr[DM_AW-1:0] : ar_out[DM_AW-1:0];

    assign w_unused_bits = ^{host_addr, pc_out, ar_out};

    sp_ram16 #(.AW(IM_AW)) u_imem (
        .clock   (clock),
        .rst_n   (rst_n),
        .i_we    (w_im_we),
        .i_waddr (host_addr[IM_AW-1:0]),
        .i_wdata (host_wdata),
        .i_raddr (w_im_raddr),
        .o_rdata (w_im_rdata)
    );

    sp_ram16 #(.AW(DM_AW)) u_dmem (
        .clock   (clock),
        .rst_n   (rst_n),
        .i_we    (w_dm_we),
        .i_waddr (w_dm_waddr),
        .i_wdata (w_dm_wdata),
        .i_raddr (w_dm_raddr),
        .o_rdata (w_dm_rdata)
    );

    // end_process is tested before the watchdog so DONE wins a same-cycle tie.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_busy   <= 1'b0;
            r_cycles <= '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    r_cycles <= sat_inc(r_cycles);
                    if (end_process) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                    end else if (r_cycles == WD_LAST) begin
                        r_state <= ST_TIMEOUT;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    if (start) begin
                        r_state  <= ST_RUN;
                        r_busy   <= 1'b1;
                        r_cycles <= '0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            r_host_rd_en <= 1'b0;
            r_host_sel   <= 1'b0;
        end else begin
            r_host_rd_en <= !w_run;
            r_host_sel   <= host_sel;
        end
    end

    assign status     = r_state;
    assign busy       = r_busy;
    assign im_out     = w_im_rdata;
    assign dm_out     = w_dm_rdata;
    assign host_rdata = r_host_rd_en ? (r_host_sel ? w_dm_rdata : w_im_rdata) : '0;

`ifdef CORE_MEM_CTRL_CYCLE_COUNT_EN
    assign cycle_count = r_cycles;
`endif

endmodule

// File: tb/tb_core_mem_ctrl.sv
// tb_core_mem_ctrl: scenario tasks with queue-based expected read data for core_mem_ctrl (MAX_CYCLES = 16).
module tb_core_mem_ctrl;
    import core_pkg::*;

    logic        clock = 1'b0;
    logic        rst_n = 1'b0;
    logic        host_we = 1'b0;
    logic        host_sel = 1'b0;
    logic [15:0] host_addr = '0;
    logic [15:0] host_wdata = '0;
    logic [15:0] host_rdata;
    logic        start = 1'b0;
    logic [1:0]  status;
    logic [15:0] pc_out = '0;
    logic [15:0] im_out;
    logic [15:0] ar_out = '0;
    logic        dm_en = 1'b0;
    logic [15:0] r2_out = '0;
    logic [15:0] dm_out;
    logic        end_process = 1'b0;
    logic        busy;
`ifdef CORE_MEM_CTRL_CYCLE_COUNT_EN
    logic [15:0] cycle_count;
`endif

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] q_im[$];
    logic [15:0] q_dm[$];
    logic [15:0] q_host[$];
    logic [15:0] imem_m [256];
    logic [15:0] dmem_m [256];

    core_mem_ctrl #(.IM_AW(8), .DM_AW(8), .MAX_CYCLES(16)) dut (
        .clock       (clock),
        .rst_n       (rst_n),
        .host_we     (host_we),
        .host_sel    (host_sel),
        .host_addr   (host_addr),
        .host_wdata  (host_wdata),
        .host_rdata  (host_rdata),
        .start       (start),
        .status      (status),
        .pc_out      (pc_out),
        .im_out      (im_out),
        .ar_out      (ar_out),
        .dm_en       (dm_en),
        .r2_out      (r2_out),
        .dm_out      (dm_out),
        .end_process (end_process),
        .busy        (busy)
`ifdef CORE_MEM_CTRL_CYCLE_COUNT_EN
        ,
        .cycle_count (cycle_count)
`endif
    );

    always #5 clock = ~clock;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic host_wr(input logic sel, input logic [15:0] addr, input logic [15:0] data);
        host_sel   = sel;
        host_addr  = addr;
        host_wdata = data;
        host_we    = 1'b1;
        step();
        host_we    = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        n_checks++; if (status !== STATUS_IDLE) begin n_errors++; $display("FAIL reset_status: got %0d expected %0d", status, STATUS_IDLE); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (im_out !== 16'h0) begin n_errors++; $display("FAIL reset_im_out: got %h expected 0000", im_out); end
        n_checks++; if (dm_out !== 16'h0) begin n_errors++; $display("FAIL reset_dm_out: got %h expected 0000", dm_out); end
        n_checks++; if (host_rdata !== 16'h0) begin n_errors++; $display("FAIL reset_host_rdata: got %h expected 0000", host_rdata); end
        rst_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic [15:0] e;
        for (int i = 0; i < 8; i++) begin
            host_wr(1'b1, 16'(i), 16'hD000 + 16'(i * 17));
            dmem_m[i] = 16'hD000 + 16'(i * 17);
        end
        host_sel = 1'b1;
        for (int i = 0; i < 8; i++) begin
            host_addr = 16'(7 - i);
            q_host.push_back(dmem_m[7 - i]);
            step();
            e = q_host.pop_front();
            n_checks++; if (host_rdata !== e) begin n_errors++; $display("FAIL b2b_host_read[%0d]: got %h expected %h", 7 - i, host_rdata, e); end
        end
    endtask

    task automatic test_load();
        logic [15:0] e;
        logic [15:0] pcs [4] = '{16'd0, 16'd1, 16'd2, 16'h0102};
        host_wr(1'b0, 16'd0, 16'd4132); imem_m[0] = 16'd4132;
        host_wr(1'b0, 16'd1, 16'd4103); imem_m[1] = 16'd4103;
        host_wr(1'b0, 16'd2, 16'd4101); imem_m[2] = 16'd4101;
        host_sel  = 1'b0;
        host_addr = 16'd1;
        q_host.push_back(imem_m[1]);
        step();
        e = q_host.pop_front();
        n_checks++; if (host_rdata !== e) begin n_errors++; $display("FAIL load_host_imem: got %h expected %h", host_rdata, e); end
        start = 1'b1; step(); start = 1'b0;
        n_checks++; if (status !== STATUS_RUN) begin n_errors++; $display("FAIL load_status: got %0d expected %0d", status, STATUS_RUN); end
        n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL load_busy: got %b expected 1", busy); end
        for (int i = 0; i < 4; i++) begin
            pc_out = pcs[i];
            q_im.push_back(imem_m[pcs[i][7:0]]);
            step();
            e = q_im.pop_front();
            n_checks++; if (im_out !== e) begin n_errors++; $display("FAIL load_im_out[pc=%h]: got %0d expected %0d", pcs[i], im_out, e); end
            if (i == 1) begin
                n_checks++; if (host_rdata !== 16'h0) begin n_errors++; $display("FAIL run_host_rdata: got %h expected 0000", host_rdata); end
            end
        end
        end_process = 1'b1; step(); end_process = 1'b0;
        n_checks++; if (status !== STATUS_DONE) begin n_errors++; $display("FAIL load_done: got %0d expected %0d", status, STATUS_DONE); end
    endtask

    task automatic test_writeback();
        logic [15:0] e;
        start = 1'b1; step(); start = 1'b0;
        ar_out = 16'd5;
        r2_out = 16'h00AB;
        dm_en  = 1'b1;
        q_dm.push_back(dmem_m[5]);
        step();
        dm_en = 1'b0;
        e = q_dm.pop_front();
        n_checks++; if (dm_out !== e) begin n_errors++; $display("FAIL wb_read_before_write: got %h expected %h", dm_out, e); end
        dmem_m[5] = 16'h00AB;
        q_dm.push_back(dmem_m[5]);
        step();
        e = q_dm.pop_front();
        n_checks++; if (dm_out !== e) begin n_errors++; $display("FAIL wb_dm_out: got %h expected %h", dm_out, e); end
        end_process = 1'b1; step(); end_process = 1'b0;
        host_sel  = 1'b1;
        host_addr = 16'd5;
        q_host.push_back(dmem_m[5]);
        step();
        e = q_host.pop_front();
        n_checks++; if (host_rdata !== e) begin n_errors++; $display("FAIL wb_host_rdata: got %h expected %h", host_rdata, e); end
    endtask

    task automatic test_completion();
        logic [15:0] e;
        host_sel = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        for (int c = 1; c < 10; c++) step();
        n_checks++; if (status !== STATUS_RUN) begin n_errors++; $display("FAIL cmp_still_run: got %0d expected %0d", status, STATUS_RUN); end
        end_process = 1'b1; step(); end_process = 1'b0;
        n_checks++; if (status !== STATUS_DONE) begin n_errors++; $display("FAIL cmp_status: got %0d expected %0d", status, STATUS_DONE); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL cmp_busy: got %b expected 0", busy); end
`ifdef CORE_MEM_CTRL_CYCLE_COUNT_EN
        n_checks++; if (cycle_count !== 16'd10) begin n_errors++; $display("FAIL cmp_cycle_count: got %0d expected 10", cycle_count); end
`endif
        ar_out = 16'd2;
        q_dm.push_back(dmem_m[2]);
        step();
        e = q_dm.pop_front();
        n_checks++; if (dm_out !== e) begin n_errors++; $display("FAIL dm_out_in_done: got %h expected %h", dm_out, e); end
        n_checks++; if (status !== STATUS_DONE) begin n_errors++; $display("FAIL done_hold: got %0d expected %0d", status, STATUS_DONE); end
`ifdef CORE_MEM_CTRL_CYCLE_COUNT_EN
        n_checks++; if (cycle_count !== 16'd10) begin n_errors++; $display("FAIL cycle_count_hold: got %0d expected 10", cycle_count); end
`endif
    endtask

    task automatic test_watchdog();
        start = 1'b1; step(); start = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            start = (c == 7);
            step();
        end
        start = 1'b0;
        n_checks++; if (status !== STATUS_RUN) begin n_errors++; $display("FAIL wd_before_expiry: got %0d expected %0d", status, STATUS_RUN); end
        step();
        n_checks++; if (status !== STATUS_TIMEOUT) begin n_errors++; $display("FAIL wd_timeout: got %0d expected %0d", status, STATUS_TIMEOUT); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL wd_busy: got %b expected 0", busy); end
`ifdef CORE_MEM_CTRL_CYCLE_COUNT_EN
        n_checks++; if (cycle_count !== 16'd16) begin n_errors++; $display("FAIL wd_cycle_count: got %0d expected 16", cycle_count); end
`endif
        start = 1'b1; step(); start = 1'b0;
        n_checks++; if (status !== STATUS_RUN) begin n_errors++; $display("FAIL wd_restart: got %0d expected %0d", status, STATUS_RUN); end
`ifdef CORE_MEM_CTRL_CYCLE_COUNT_EN
        n_checks++; if (cycle_count !== 16'd0) begin n_errors++; $display("FAIL wd_restart_count: got %0d expected 0", cycle_count); end
`endif
        for (int c = 1; c <= 15; c++) step();
        end_process = 1'b1; step(); end_process = 1'b0;
        n_checks++; if (status !== STATUS_DONE) begin n_errors++; $display("FAIL wd_tie_done: got %0d expected %0d", status, STATUS_DONE); end
    endtask

    task automatic test_guard_run();
        logic [15:0] e;
        start = 1'b1; step(); start = 1'b0;
        host_wr(1'b1, 16'd3, 16'h1234);
        host_wr(1'b0, 16'd0, 16'hFFFF);
        end_process = 1'b1; step(); end_process = 1'b0;
        host_sel  = 1'b1;
        host_addr = 16'd3;
        q_host.push_back(dmem_m[3]);
        step();
        e = q_host.pop_front();
        n_checks++; if (host_rdata !== e) begin n_errors++; $display("FAIL guard_run_dmem: got %h expected %h", host_rdata, e); end
        host_sel  = 1'b0;
        host_addr = 16'd0;
        q_host.push_back(imem_m[0]);
        step();
        e = q_host.pop_front();
        n_checks++; if (host_rdata !== e) begin n_errors++; $display("FAIL guard_run_imem: got %h expected %h", host_rdata, e); end
    endtask

    task automatic test_reset_mid_run();
        logic [15:0] e;
        start = 1'b1; step(); start = 1'b0;
        step();
        step();
        rst_n  = 1'b0;
        dm_en  = 1'b1;
        ar_out = 16'd4;
        r2_out = 16'hFFFF;
        step();
        n_checks++; if (status !== STATUS_IDLE) begin n_errors++; $display("FAIL rst_run_status: got %0d expected %0d", status, STATUS_IDLE); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL rst_run_busy: got %b expected 0", busy); end
        n_checks++; if (im_out !== 16'h0) begin n_errors++; $display("FAIL rst_run_im_out: got %h expected 0000", im_out); end
        n_checks++; if (dm_out !== 16'h0) begin n_errors++; $display("FAIL rst_run_dm_out: got %h expected 0000", dm_out); end
        n_checks++; if (host_rdata !== 16'h0) begin n_errors++; $display("FAIL rst_run_host_rdata: got %h expected 0000", host_rdata); end
`ifdef CORE_MEM_CTRL_CYCLE_COUNT_EN
        n_checks++; if (cycle_count !== 16'd0) begin n_errors++; $display("FAIL rst_run_cycle_count: got %0d expected 0", cycle_count); end
`endif
        rst_n = 1'b1;
        dm_en = 1'b0;
        host_sel  = 1'b1;
        host_addr = 16'd4;
        q_host.push_back(dmem_m[4]);
        step();
        e = q_host.pop_front();
        n_checks++; if (host_rdata !== e) begin n_errors++; $display("FAIL rst_dmem_kept: got %h expected %h", host_rdata, e); end
        host_sel  = 1'b0;
        host_addr = 16'd2;
        q_host.push_back(imem_m[2]);
        step();
        e = q_host.pop_front();
        n_checks++; if (host_rdata !== e) begin n_errors++; $display("FAIL rst_imem_kept: got %h expected %h", host_rdata, e); end
    endtask

    task automatic test_guard_idle();
        logic [15:0] e;
        host_sel = 1'b0;
        dm_en    = 1'b1;
        ar_out   = 16'd3;
        r2_out   = 16'hBEEF;
        step();
        dm_en = 1'b0;
        n_checks++; if (status !== STATUS_IDLE) begin n_errors++; $display("FAIL guard_idle_status: got %0d expected %0d", status, STATUS_IDLE); end
        host_sel  = 1'b1;
        host_addr = 16'd3;
        q_host.push_back(dmem_m[3]);
        step();
        e = q_host.pop_front();
        n_checks++; if (host_rdata !== e) begin n_errors++; $display("FAIL guard_idle_dmem: got %h expected %h", host_rdata, e); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_load();
        test_writeback();
        test_completion();
        test_watchdog();
        test_guard_run();
        test_reset_mid_run();
        test_guard_idle();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
